// File: rtl/alu_secuenciador.sv
// alu_secuenciador: byte-stream command front end for the flagged 8-bit ALU.
// Collects A, B and a command byte, runs the ALU for one cycle, returns bytes.
module alu_secuenciador #(
    parameter bit SEND_FLAGS = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       A,
    output logic [7:0]       B,
    output logic [2:0]       ALUControl,
    output logic [2:0]       Cantidad,
    input  logic [7:0]       Resultado,
    input  logic             Carry,
    input  logic             Overflow,
    input  logic             Negative,
    input  logic             Zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] LOAD_A   = 3'd0;
    localparam logic [2:0] LOAD_B   = 3'd1;
    localparam logic [2:0] LOAD_CMD = 3'd2;
    localparam logic [2:0] EXEC     = 3'd3;
    localparam logic [2:0] SEND_RES = 3'd4;
    localparam logic [2:0] SEND_FLG = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [2:0]       ctl_q, ctl_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       res_q, res_d;
    logic [7:0]       flg_q, flg_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic in_xfer;
    logic out_xfer;
    logic unused_cmd_bits;

    // Command bits 7:6 carry no meaning for the ALU.
    assign unused_cmd_bits = ^in_data[7:6];

    assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B) ||
                       (state_q == LOAD_CMD);
    assign out_valid = (state_q == SEND_RES) || (state_q == SEND_FLG);
    assign busy      = (state_q != LOAD_A);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    assign A          = a_q;
    assign B          = b_q;
    assign ALUControl = ctl_q;
    assign Cantidad   = cnt_q;
    assign op_count   = op_count_q;

    // Response byte is a pure function of state and the captured registers.
    always_comb begin
        case (state_q)
            SEND_RES: out_data = res_q;
            SEND_FLG: out_data = flg_q;
            default:  out_data = 8'h00;
        endcase
    end

    // Sequencer: load three bytes, one execute cycle, then send response.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        ctl_d      = ctl_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        flg_d      = flg_q;
        op_count_d = op_count_q;
        case (state_q)
            LOAD_A: begin
                if (in_xfer) begin
                    a_d     = in_data;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_xfer) begin
                    b_d     = in_data;
                    state_d = LOAD_CMD;
                end
            end
            LOAD_CMD: begin
                if (in_xfer) begin
                    ctl_d   = in_data[2:0];
                    cnt_d   = in_data[5:3];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = Resultado;
                flg_d   = {4'b0000, Negative, Zero, Carry, Overflow};
                state_d = SEND_RES;
            end
            SEND_RES: begin
                if (out_xfer) begin
                    if (SEND_FLAGS) begin
                        state_d = SEND_FLG;
                    end else begin
                        op_count_d = op_count_q + CNT_ONE;
                        state_d    = LOAD_A;
                    end
                end
            end
            SEND_FLG: begin
                if (out_xfer) begin
                    op_count_d = op_count_q + CNT_ONE;
                    state_d    = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    // State and datapath registers; reset discards any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD_A;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            ctl_q      <= 3'b000;
            cnt_q      <= 3'b000;
            res_q      <= 8'h00;
            flg_q      <= 8'h00;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctl_q      <= ctl_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            flg_q      <= flg_d;
            op_count_q <= op_count_d;
        end
    end

endmodule

// File: tb/tb_alu_secuenciador.sv
// tb_alu_secuenciador: directed bench for the ALU sequencer.
// The ALU is modelled as an 8-bit add with N/Z/C/V flags.
module tb_alu_secuenciador;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic       sel;

    int total = 0;
    int bad   = 0;

    // Instance a: SEND_FLAGS=1, CNT_W=8
    logic       in_valid_a, in_ready_a, out_valid_a, busy_a;
    logic [7:0] out_data_a, a_a, b_a, res_a, op_count_a;
    logic [2:0] ctl_a, cnt_a;
    logic       c_a, v_a, n_a, z_a;

    // Instance b: SEND_FLAGS=0, CNT_W=2
    logic       in_valid_b, in_ready_b, out_valid_b, busy_b;
    logic [7:0] out_data_b, a_b, b_b, res_b;
    logic [2:0] ctl_b, cnt_b;
    logic [1:0] op_count_b;
    logic       c_b, v_b, n_b, z_b;

    logic       in_ready_m, out_valid_m, busy_m;
    logic [7:0] out_data_m;

    always #5 clk = ~clk;

    assign in_valid_a = in_valid & ~sel;
    assign in_valid_b = in_valid & sel;
    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign out_data_m  = sel ? out_data_b  : out_data_a;
    assign busy_m      = sel ? busy_b      : busy_a;

    assign {c_a, res_a} = {1'b0, a_a} + {1'b0, b_a};
    assign n_a = res_a[7];
    assign z_a = (res_a == 8'h00);
    assign v_a = (a_a[7] == b_a[7]) && (res_a[7] != a_a[7]);

    assign {c_b, res_b} = {1'b0, a_b} + {1'b0, b_b};
    assign n_b = res_b[7];
    assign z_b = (res_b == 8'h00);
    assign v_b = (a_b[7] == b_b[7]) && (res_b[7] != a_b[7]);

    alu_secuenciador #(.SEND_FLAGS(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready),
        .A(a_a), .B(b_a), .ALUControl(ctl_a), .Cantidad(cnt_a),
        .Resultado(res_a), .Carry(c_a), .Overflow(v_a),
        .Negative(n_a), .Zero(z_a),
        .busy(busy_a), .op_count(op_count_a)
    );

    alu_secuenciador #(.SEND_FLAGS(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready),
        .A(a_b), .B(b_b), .ALUControl(ctl_b), .Cantidad(cnt_b),
        .Resultado(res_b), .Carry(c_b), .Overflow(v_b),
        .Negative(n_b), .Zero(z_b),
        .busy(busy_b), .op_count(op_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready_m && n < 20) begin
            step();
            n++;
        end
        chk("put_ready", in_ready_m, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic get(input string tag, input logic [7:0] exp);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid_m && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, out_valid_m, 1);
        chk(tag, out_data_m, exp);
        step();
    endtask

    task automatic req(input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] c);
        put(x);
        put(y);
        put(c);
        chk("exec_in_ready", in_ready_m, 0);
        chk("exec_out_valid", out_valid_m, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = 1'b0;
        #12;
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_out_data", out_data_a, 8'h00);
        chk("rst_op_count", op_count_a, 0);
        chk("rst_A", a_a, 0);
        chk("rst_b_op_count", op_count_b, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Test 1: 0x7F + 0x01, latency check
        req(8'h7F, 8'h01, 8'h00);
        chk("t1_exec_busy", busy_a, 1);
        step();
        chk("t1_lat_valid", out_valid_a, 1);
        get("t1_res", 8'h80);
        get("t1_flg", 8'h09);
        chk("t1_op_count", op_count_a, 1);
        chk("t1_busy", busy_a, 0);
        chk("t1_idle_valid", out_valid_a, 0);

        // Test 2: 0xFF + 0x01 back to back
        req(8'hFF, 8'h01, 8'h00);
        get("t2_res", 8'h00);
        get("t2_flg", 8'h06);
        chk("t2_op_count", op_count_a, 2);

        // Test 3: backpressure in SEND_RES
        out_ready = 1'b0;
        req(8'h10, 8'h20, 8'h00);
        step();
        for (int i = 0; i < 5; i++) begin
            in_data  = 8'h55;
            in_valid = (i % 2 == 0);
            chk("t3_valid", out_valid_a, 1);
            chk("t3_data", out_data_a, 8'h30);
            chk("t3_in_ready", in_ready_a, 0);
            step();
        end
        in_valid = 1'b0;
        chk("t3_A_kept", a_a, 8'h10);
        get("t3_res", 8'h30);
        get("t3_flg", 8'h00);
        chk("t3_op_count", op_count_a, 3);

        // Test 4: command decode 0xE9
        req(8'h05, 8'h03, 8'hE9);
        chk("t4_ctl", ctl_a, 3'b001);
        chk("t4_cnt", cnt_a, 3'b101);
        step();
        chk("t4_res_A", a_a, 8'h05);
        chk("t4_res_B", b_a, 8'h03);
        chk("t4_res_ctl", ctl_a, 3'b001);
        chk("t4_res_cnt", cnt_a, 3'b101);
        get("t4_res", 8'h08);
        chk("t4_flg_A", a_a, 8'h05);
        chk("t4_flg_B", b_a, 8'h03);
        chk("t4_flg_ctl", ctl_a, 3'b001);
        chk("t4_flg_cnt", cnt_a, 3'b101);
        get("t4_flg", 8'h00);
        chk("t4_op_count", op_count_a, 4);

        // Test 5a: reset in LOAD_CMD
        put(8'h44);
        put(8'h22);
        chk("t5_pre_busy", busy_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5a_busy", busy_a, 0);
        chk("t5a_in_ready", in_ready_a, 1);
        chk("t5a_out_valid", out_valid_a, 0);
        chk("t5a_A", a_a, 0);
        chk("t5a_B", b_a, 0);
        chk("t5a_op_count", op_count_a, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Test 5b: reset in SEND_FLG
        req(8'h01, 8'h01, 8'h00);
        get("t5b_res", 8'h02);
        chk("t5b_pre_valid", out_valid_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5b_out_valid", out_valid_a, 0);
        chk("t5b_out_data", out_data_a, 0);
        chk("t5b_busy", busy_a, 0);
        chk("t5b_in_ready", in_ready_a, 1);
        chk("t5b_op_count", op_count_a, 0);
        chk("t5b_A", a_a, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        req(8'h80, 8'h80, 8'h00);
        get("t5c_res", 8'h00);
        get("t5c_flg", 8'h07);
        chk("t5c_op_count", op_count_a, 1);

        // Test 6: single-byte responses, 2-bit counter
        sel = 1'b1;
        step();
        req(8'h01, 8'h02, 8'h00);
        get("t6_res0", 8'h03);
        chk("t6_one_byte0", out_valid_b, 0);
        chk("t6_cnt0", op_count_b, 1);
        req(8'h10, 8'h10, 8'h00);
        get("t6_res1", 8'h20);
        chk("t6_cnt1", op_count_b, 2);
        req(8'hF0, 8'h20, 8'h00);
        get("t6_res2", 8'h10);
        chk("t6_cnt2", op_count_b, 3);
        req(8'h40, 8'h40, 8'h00);
        get("t6_res3", 8'h80);
        chk("t6_cnt3", op_count_b, 0);
        req(8'hAA, 8'h11, 8'h00);
        get("t6_res4", 8'hBB);
        chk("t6_one_byte4", out_valid_b, 0);
        chk("t6_cnt4", op_count_b, 1);
        chk("t6_busy", busy_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
